// File: rtl/mem_responder.sv
// Memory responder: accepts one read or write at a time, performs it LATENCY
// edges after accept, pulses done, and parks in HALTED when the CPU halts.
module mem_responder #(
  parameter int LATENCY = 2,
  parameter int DEPTH   = 256
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       memRead,
  input  logic       memWrite,
  input  logic [7:0] addr,
  input  logic [7:0] wdata,
  input  logic       halt,
  output logic [7:0] rdata,
  output logic       stall,
  output logic       done,
  output logic       err,
  output logic       halted
);
  // DEPTH is a power of two between 2 and 256, so the modulo is a bit slice
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {IDLE, BUSY, DONE, HALTED} state_t;

  state_t        state, state_n;
  logic [3:0]    cnt, cnt_n;
  logic [7:0]    addr_q, wdata_q;
  logic          wr_q;
  logic          accept, access;
  logic [AW-1:0] midx;
  logic [7:0]    mem [DEPTH];

  assign midx   = addr_q[AW-1:0];
  assign halted = (state == HALTED);

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    stall   = 1'b0;
    done    = 1'b0;
    err     = 1'b0;
    accept  = 1'b0;
    access  = 1'b0;
    unique case (state)
      IDLE: begin
        if (halt) state_n = HALTED;
        else if (memRead ^ memWrite) begin
          accept  = 1'b1;
          stall   = 1'b1;
          cnt_n   = 4'(LATENCY - 1);
          state_n = BUSY;
        end else if (memRead && memWrite) err = 1'b1;
      end
      BUSY: begin
        stall = 1'b1;
        if (cnt != 4'd0) cnt_n = cnt - 4'd1;
        else begin
          access  = 1'b1;
          state_n = DONE;
        end
      end
      DONE: begin
        done    = 1'b1;
        state_n = IDLE;
      end
      default: ;
    endcase
    // stall/err decode raw inputs in IDLE; keep them quiet while reset is held
    if (!rst_n) begin
      stall = 1'b0;
      err   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= 4'd0;
      addr_q  <= 8'h00;
      wdata_q <= 8'h00;
      wr_q    <= 1'b0;
      rdata   <= 8'h00;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      if (accept) begin
        addr_q  <= addr;
        wdata_q <= wdata;
        wr_q    <= memWrite;
      end
      if (access && !wr_q) rdata <= mem[midx];
    end
  end

  // storage survives reset; reset forces IDLE so an aborted write never lands
  always_ff @(posedge clk) begin
    if (access && wr_q) mem[midx] <= wdata_q;
  end
endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: a LATENCY=2/DEPTH=256 instance for the main
// scenarios and a LATENCY=1/DEPTH=128 instance for the wrap case.
module tb_mem_responder;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       memRead = 1'b0, memWrite = 1'b0, halt = 1'b0;
  logic [7:0] addr = 8'h00, wdata = 8'h00;
  logic [7:0] rdata1, rdata2;
  logic       stall1, done1, err1, halted1;
  logic       stall2, done2, err2, halted2;
  int         tests = 0, fails = 0;
  int         ns, ne;

  always #5 clk = ~clk;

  mem_responder #(.LATENCY(2), .DEPTH(256)) dut1 (
    .clk(clk), .rst_n(rst_n), .memRead(memRead), .memWrite(memWrite),
    .addr(addr), .wdata(wdata), .halt(halt), .rdata(rdata1),
    .stall(stall1), .done(done1), .err(err1), .halted(halted1));

  mem_responder #(.LATENCY(1), .DEPTH(128)) dut2 (
    .clk(clk), .rst_n(rst_n), .memRead(memRead), .memWrite(memWrite),
    .addr(addr), .wdata(wdata), .halt(halt), .rdata(rdata2),
    .stall(stall2), .done(done2), .err(err2), .halted(halted2));

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Issue one request on instance sel; after the accept edge apply a2/d2 to
  // the data inputs. ns = cycles with stall high, ne = edges from accept
  // (inclusive) to the first cycle where done is high.
  task automatic do_req(input int sel, input logic rd, input logic wr,
                        input logic [7:0] a, input logic [7:0] d,
                        input logic [7:0] a2, input logic [7:0] d2,
                        output int nstall, output int nedge);
    logic st, dn;
    memRead = rd; memWrite = wr; addr = a; wdata = d;
    nstall = 0; nedge = 0;
    @(negedge clk);
    if ((sel == 1) ? stall1 : stall2) nstall++;
    tick();
    memRead = 1'b0; memWrite = 1'b0; addr = a2; wdata = d2;
    nedge = 1;
    while (nedge < 20) begin
      @(negedge clk);
      st = (sel == 1) ? stall1 : stall2;
      dn = (sel == 1) ? done1 : done2;
      if (dn) break;
      if (st) nstall++;
      tick();
      nedge++;
    end
    tick();
  endtask

  initial begin
    // reset state
    addr = 8'h10; memRead = 1'b1;
    #12;
    chk("rst_rdata", rdata1, 8'h00);
    chk("rst_stall", {7'd0, stall1}, 8'h00);
    chk("rst_done", {7'd0, done1}, 8'h00);
    chk("rst_halted", {7'd0, halted1}, 8'h00);
    chk("rst_stall2", {7'd0, stall2}, 8'h00);
    memRead = 1'b0;
    tick(); rst_n = 1'b1; tick();

    // write then read at LATENCY=2
    do_req(1, 1'b0, 1'b1, 8'h10, 8'hA5, 8'h10, 8'hA5, ns, ne);
    chk("wr_stall_cycles", 8'(ns), 8'd3);
    chk("wr_done_edges", 8'(ne), 8'd3);
    chk("wr_rdata_untouched", rdata1, 8'h00);
    tick();
    do_req(1, 1'b1, 1'b0, 8'h10, 8'h00, 8'h10, 8'h00, ns, ne);
    chk("rd_stall_cycles", 8'(ns), 8'd3);
    chk("rd_done_edges", 8'(ne), 8'd3);
    chk("rd_rdata", rdata1, 8'hA5);
    @(negedge clk);
    chk("done_one_cycle", {7'd0, done1}, 8'h00);
    tick();

    // illegal request
    memRead = 1'b1; memWrite = 1'b1; addr = 8'h10; wdata = 8'h00;
    @(negedge clk);
    chk("ill_err", {7'd0, err1}, 8'h01);
    chk("ill_stall", {7'd0, stall1}, 8'h00);
    tick();
    memRead = 1'b0; memWrite = 1'b0;
    @(negedge clk);
    chk("ill_err_clear", {7'd0, err1}, 8'h00);
    chk("ill_no_done", {7'd0, done1}, 8'h00);
    tick();
    do_req(1, 1'b1, 1'b0, 8'h10, 8'h00, 8'h10, 8'h00, ns, ne);
    chk("ill_mem_unchanged", rdata1, 8'hA5);
    chk("ill_idle_stays", 8'(ne), 8'd3);
    tick();

    // input change during BUSY
    do_req(1, 1'b0, 1'b1, 8'h20, 8'h3C, 8'h20, 8'h3C, ns, ne); tick();
    do_req(1, 1'b0, 1'b1, 8'h21, 8'h77, 8'h21, 8'h77, ns, ne); tick();
    do_req(1, 1'b1, 1'b0, 8'h20, 8'h00, 8'h21, 8'hEE, ns, ne);
    chk("busy_addr_change", rdata1, 8'h3C);
    tick();

    // halt during BUSY
    memWrite = 1'b1; addr = 8'h30; wdata = 8'h99;
    tick();
    memWrite = 1'b0; halt = 1'b1;
    @(negedge clk);
    chk("halt_busy_stall", {7'd0, stall1}, 8'h01);
    tick(); tick();
    @(negedge clk);
    chk("halt_done", {7'd0, done1}, 8'h01);
    chk("halt_not_yet", {7'd0, halted1}, 8'h00);
    tick();
    @(negedge clk);
    chk("halt_idle_stall", {7'd0, stall1}, 8'h00);
    tick();
    @(negedge clk);
    chk("halted", {7'd0, halted1}, 8'h01);
    halt = 1'b0; memRead = 1'b1; memWrite = 1'b1;
    @(negedge clk);
    chk("halted_no_err", {7'd0, err1}, 8'h00);
    memWrite = 1'b0;
    ns = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (stall1 || done1) ns++;
      tick();
    end
    chk("halted_ignores_read", 8'(ns), 8'd0);
    chk("halted_sticky", {7'd0, halted1}, 8'h01);
    memRead = 1'b0;
    rst_n = 1'b0; tick(); rst_n = 1'b1; tick();
    chk("halt_reset_clears", {7'd0, halted1}, 8'h00);
    do_req(1, 1'b1, 1'b0, 8'h30, 8'h00, 8'h30, 8'h00, ns, ne);
    chk("halt_write_landed", rdata1, 8'h99);
    tick();

    // reset mid-BUSY
    do_req(1, 1'b0, 1'b1, 8'h05, 8'h11, 8'h05, 8'h11, ns, ne); tick();
    memWrite = 1'b1; addr = 8'h05; wdata = 8'hFF;
    tick();
    memWrite = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_rdata", rdata1, 8'h00);
    chk("mid_rst_stall", {7'd0, stall1}, 8'h00);
    chk("mid_rst_done", {7'd0, done1}, 8'h00);
    tick(); tick(); tick();
    rst_n = 1'b1; tick();
    do_req(1, 1'b1, 1'b0, 8'h05, 8'h00, 8'h05, 8'h00, ns, ne);
    chk("mid_rst_no_write", rdata1, 8'h11);
    tick(); tick();

    // LATENCY=1, DEPTH=128 wrap
    do_req(2, 1'b0, 1'b1, 8'h7F, 8'h5A, 8'h7F, 8'h5A, ns, ne);
    tick(); tick(); tick();
    do_req(2, 1'b1, 1'b0, 8'hFF, 8'h00, 8'hFF, 8'h00, ns, ne);
    chk("wrap_done_edges", 8'(ne), 8'd2);
    chk("wrap_stall_cycles", 8'(ns), 8'd2);
    chk("wrap_rdata", rdata2, 8'h5A);
    tick(); tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
